// File: rtl/dm_sba_bus_bridge_pkg.sv
// Shared definitions for the debug-module SBA bus bridge: FSM encodings,
// response error-flag bit positions and the timeout counter sizing rule.
package dm_sba_bus_bridge_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Bit positions inside the two-bit response error flag register
    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_WINDOW  = 1;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/dm_sba_bus_bridge_timeout.sv
// Response timeout counter: cleared while idle, counts while enabled,
// saturates, and flags the cycle in which the count equals TimeoutCycles-1.
module dm_bus_timeout
    import dm_sba_bus_bridge_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned     CntW    = cnt_width(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = (r_cnt == CntLast);

endmodule

// File: rtl/dm_sba_bus_bridge.sv
// Bridges the DM system-bus master (req/gnt/r_valid) onto the single-outstanding
// strobe/ready memory port, with an address-window check and a response timeout.
module dm_sba_bus_bridge
    import dm_sba_bus_bridge_pkg::*;
#(
    parameter int unsigned          BusWidth      = 32,
    parameter logic [BusWidth-1:0]  WinBase       = '0,
    parameter logic [BusWidth-1:0]  WinLimit      = '1,
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    master_req_i,
    input  logic [BusWidth-1:0]     master_add_i,
    input  logic                    master_we_i,
    input  logic [BusWidth-1:0]     master_wdata_i,
    input  logic [BusWidth/8-1:0]   master_be_i,
    output logic                    master_gnt_o,
    output logic                    master_r_valid_o,
    output logic                    master_r_err_o,
    output logic                    master_r_other_err_o,
    output logic [BusWidth-1:0]     master_r_rdata_o,
    output logic                    p_strobe_o,
    output logic [BusWidth-1:0]     p_addr_o,
    output logic                    p_rw_o,
    output logic [BusWidth/8-1:0]   p_byte_enable_o,
    output logic [BusWidth-1:0]     p_wt_data_o,
    input  logic                    p_ready_i,
    input  logic [BusWidth-1:0]     p_data_i
);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [BusWidth-1:0]    r_addr;
    logic [BusWidth-1:0]    r_wdata;
    logic [BusWidth-1:0]    r_rdata;
    logic                   r_we;
    logic [BusWidth/8-1:0]  r_be;
    logic [1:0]             r_err_flags;

    logic w_below;
    logic w_above;
    logic w_out_of_win;
    logic w_expired;
    logic w_resp;

    // Bounds sitting at the ends of the address space cannot be violated
    generate
        if (WinBase == '0) begin : g_no_lo
            assign w_below = 1'b0;
        end else begin : g_lo
            assign w_below = (master_add_i < WinBase);
        end
        if (WinLimit == '1) begin : g_no_hi
            assign w_above = 1'b0;
        end else begin : g_hi
            assign w_above = (master_add_i > WinLimit);
        end
    endgenerate

    assign w_out_of_win = w_below | w_above;

    dm_bus_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (r_state == ST_IDLE),
        .enable_i  ((r_state == ST_ISSUE) || (r_state == ST_WAIT)),
        .expired_o (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (master_req_i) w_state_nxt = w_out_of_win ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_state_nxt = p_ready_i ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (p_ready_i || w_expired) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_err_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (master_req_i) begin
                        r_addr                  <= master_add_i;
                        r_wdata                 <= master_wdata_i;
                        r_we                    <= master_we_i;
                        r_be                    <= master_be_i;
                        r_rdata                 <= '0;
                        r_err_flags             <= '0;
                        r_err_flags[ERR_WINDOW] <= w_out_of_win;
                    end
                end
                ST_ISSUE: begin
                    if (p_ready_i && !r_we) r_rdata <= p_data_i;
                end
                ST_WAIT: begin
                    // A ready arriving on the expiry cycle still completes normally
                    if (p_ready_i) begin
                        if (!r_we) r_rdata <= p_data_i;
                    end else if (w_expired) begin
                        r_err_flags[ERR_TIMEOUT] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_resp               = (r_state == ST_RESP);
    assign master_gnt_o         = rst_ni & (r_state == ST_IDLE) & master_req_i;
    assign master_r_valid_o     = w_resp;
    assign master_r_err_o       = w_resp & r_err_flags[ERR_TIMEOUT];
    assign master_r_other_err_o = w_resp & r_err_flags[ERR_WINDOW];
    assign master_r_rdata_o     = {BusWidth{w_resp}} & r_rdata;
    assign p_strobe_o           = (r_state == ST_ISSUE);
    assign p_addr_o             = r_addr;
    assign p_rw_o               = r_we;
    assign p_byte_enable_o      = r_be;
    assign p_wt_data_o          = r_wdata;

endmodule

// File: tb/tb_dm_sba_bus_bridge.sv
// Self-checking bench for dm_sba_bus_bridge: directed vector table, multi-cycle
// corner sequences and randomized transactions against a behavioural model.
module tb_dm_sba_bus_bridge;

    localparam int unsigned TO    = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] LIMIT = 32'hBFFF_FFFF;
    localparam int          NEVER = 99;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        master_req_i = 1'b0;
    logic [31:0] master_add_i = '0;
    logic        master_we_i = 1'b0;
    logic [31:0] master_wdata_i = '0;
    logic [3:0]  master_be_i = '0;
    logic        master_gnt_o;
    logic        master_r_valid_o;
    logic        master_r_err_o;
    logic        master_r_other_err_o;
    logic [31:0] master_r_rdata_o;
    logic        p_strobe_o;
    logic [31:0] p_addr_o;
    logic        p_rw_o;
    logic [3:0]  p_byte_enable_o;
    logic [31:0] p_wt_data_o;
    logic        p_ready_i = 1'b0;
    logic [31:0] p_data_i = '0;

    int total = 0;
    int bad   = 0;

    dm_sba_bus_bridge #(
        .BusWidth      (32),
        .WinBase       (BASE),
        .WinLimit      (LIMIT),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .master_req_i         (master_req_i),
        .master_add_i         (master_add_i),
        .master_we_i          (master_we_i),
        .master_wdata_i       (master_wdata_i),
        .master_be_i          (master_be_i),
        .master_gnt_o         (master_gnt_o),
        .master_r_valid_o     (master_r_valid_o),
        .master_r_err_o       (master_r_err_o),
        .master_r_other_err_o (master_r_other_err_o),
        .master_r_rdata_o     (master_r_rdata_o),
        .p_strobe_o           (p_strobe_o),
        .p_addr_o             (p_addr_o),
        .p_rw_o               (p_rw_o),
        .p_byte_enable_o      (p_byte_enable_o),
        .p_wt_data_o          (p_wt_data_o),
        .p_ready_i            (p_ready_i),
        .p_data_i             (p_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;   // cycles from strobe to p_ready_i pulse
        logic [31:0] pdata;
        logic        exp_err;
        logic        exp_oerr;
        logic [31:0] exp_rdata;
        int          exp_lat; // gnt cycle to r_valid cycle
        int          exp_strobes;
    } vec_t;

    typedef struct {
        int          gnts;
        int          strobes;
        int          rvs;
        int          lat;
        int          hold_bad;
        logic        err;
        logic        oerr;
        logic [31:0] rdata;
    } res_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; acts as a reactive memory-side slave.
    task automatic run_txn(input vec_t v, output res_t r);
        int gnt_c, strobe_c, rv_c;
        gnt_c = -1; strobe_c = -1; rv_c = -1;
        r.gnts = 0; r.strobes = 0; r.rvs = 0; r.lat = -1; r.hold_bad = 0;
        r.err = 1'bx; r.oerr = 1'bx; r.rdata = 'x;
        master_add_i   = v.addr;
        master_we_i    = v.we;
        master_wdata_i = v.wdata;
        master_be_i    = v.be;
        master_req_i   = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c > 0) @(negedge clk_i);
            if (gnt_c >= 0) master_req_i = 1'b0;
            if (p_strobe_o) begin
                r.strobes++;
                if (strobe_c < 0) strobe_c = c;
            end
            if (strobe_c >= 0 && rv_c < 0 &&
                {p_addr_o, p_rw_o, p_byte_enable_o, p_wt_data_o} !== {v.addr, v.we, v.be, v.wdata})
                r.hold_bad++;
            if (master_r_valid_o) begin
                r.rvs++;
                if (rv_c < 0) begin
                    rv_c    = c;
                    r.err   = master_r_err_o;
                    r.oerr  = master_r_other_err_o;
                    r.rdata = master_r_rdata_o;
                end
            end
            p_ready_i = (strobe_c >= 0) && (c == strobe_c + v.delay);
            p_data_i  = p_ready_i ? v.pdata : $urandom;
            #1;
            if (master_gnt_o) begin
                r.gnts++;
                if (gnt_c < 0) gnt_c = c;
            end
            if (rv_c >= 0 && c >= rv_c + 4) break;
        end
        p_ready_i    = 1'b0;
        master_req_i = 1'b0;
        if (rv_c >= 0 && gnt_c >= 0) r.lat = rv_c - gnt_c;
        @(negedge clk_i);
    endtask

    task automatic check_txn(input string tag, input vec_t v, input res_t r);
        chk({tag, "_gnts"},    r.gnts, 1);
        chk({tag, "_strobes"}, r.strobes, v.exp_strobes);
        chk({tag, "_rvalids"}, r.rvs, 1);
        chk({tag, "_latency"}, r.lat, v.exp_lat);
        chk({tag, "_err"},     r.err, v.exp_err);
        chk({tag, "_oerr"},    r.oerr, v.exp_oerr);
        chk({tag, "_rdata"},   r.rdata, v.exp_rdata);
        chk({tag, "_hold"},    r.hold_bad, 0);
    endtask

    // Behavioural expectation from the bridge's rules
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        if (v.addr < BASE || v.addr > LIMIT) begin
            e.exp_err = 1'b0; e.exp_oerr = 1'b1; e.exp_rdata = '0;
            e.exp_lat = 1;    e.exp_strobes = 0;
        end else if (v.delay <= int'(TO) - 1) begin
            e.exp_err = 1'b0; e.exp_oerr = 1'b0; e.exp_rdata = v.we ? 32'h0 : v.pdata;
            e.exp_lat = v.delay + 2; e.exp_strobes = 1;
        end else begin
            e.exp_err = 1'b1; e.exp_oerr = 1'b0; e.exp_rdata = '0;
            e.exp_lat = int'(TO) + 1; e.exp_strobes = 1;
        end
        return e;
    endfunction

    function automatic logic outs_nonzero();
        return |{master_gnt_o, master_r_valid_o, master_r_err_o, master_r_other_err_o,
                 master_r_rdata_o, p_strobe_o, p_addr_o, p_rw_o, p_byte_enable_o, p_wt_data_o};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        res_t r;
        int   gn, sn, rn, ov;

        tbl[0]  = '{32'h8000_0010, 1'b0, 32'h0,         4'hF, 0,     32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 2,  1};
        tbl[1]  = '{32'h8000_0004, 1'b1, 32'h1234_5678, 4'h3, 5,     32'h5555_AAAA, 1'b0, 1'b0, 32'h0,         7,  1};
        tbl[2]  = '{32'h0000_1000, 1'b0, 32'h0,         4'hF, 0,     32'h1111_1111, 1'b0, 1'b1, 32'h0,         1,  0};
        tbl[3]  = '{32'h8000_0000, 1'b0, 32'h0,         4'hF, 1,     32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 3,  1};
        tbl[4]  = '{32'h7FFF_FFFC, 1'b0, 32'h0,         4'hF, 0,     32'h2222_2222, 1'b0, 1'b1, 32'h0,         1,  0};
        tbl[5]  = '{32'hBFFF_FFFF, 1'b0, 32'h0,         4'h1, 2,     32'hA5A5_A5A5, 1'b0, 1'b0, 32'hA5A5_A5A5, 4,  1};
        tbl[6]  = '{32'hC000_0000, 1'b1, 32'hCAFE_0000, 4'hF, 0,     32'h3333_3333, 1'b0, 1'b1, 32'h0,         1,  0};
        tbl[7]  = '{32'h8000_0100, 1'b0, 32'h0,         4'hF, 15,    32'h1357_9BDF, 1'b0, 1'b0, 32'h1357_9BDF, 17, 1};
        tbl[8]  = '{32'h8000_0200, 1'b0, 32'h0,         4'hF, 19,    32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         17, 1};
        tbl[9]  = '{32'h8000_0300, 1'b0, 32'h0,         4'hF, 0,     32'h0000_00FF, 1'b0, 1'b0, 32'h0000_00FF, 2,  1};
        tbl[10] = '{32'h9000_0000, 1'b1, 32'h0F0F_0F0F, 4'hC, 16,    32'h4444_4444, 1'b1, 1'b0, 32'h0,         17, 1};

        // Reset: outputs quiet and no grant even with a request pending
        master_req_i = 1'b1;
        master_add_i = 32'h8000_0000;
        repeat (3) @(negedge clk_i);
        #1;
        chk("reset_gnt", master_gnt_o, 0);
        chk("reset_outs", outs_nonzero(), 0);
        @(negedge clk_i);
        master_req_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i], r);
            check_txn($sformatf("vec%0d", i), tbl[i], r);
        end

        // Reset while waiting on the slave
        master_add_i = 32'h8000_0080;
        master_we_i  = 1'b0;
        master_req_i = 1'b1;
        @(negedge clk_i);
        master_req_i = 1'b0;
        chk("midrst_strobe", p_strobe_o, 1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        master_req_i = 1'b1;
        #1;
        chk("midrst_outs", outs_nonzero(), 0);
        @(posedge clk_i);
        #1;
        chk("midrst_outs_held", outs_nonzero(), 0);
        @(negedge clk_i);
        master_req_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_txn(tbl[0], r);
        check_txn("postrst", tbl[0], r);

        // Request held high with a zero-wait slave: 3-cycle transaction cadence
        gn = 0; sn = 0; rn = 0; ov = 0;
        master_add_i = 32'h8000_0040;
        master_we_i  = 1'b0;
        master_req_i = 1'b1;
        p_ready_i    = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk_i);
            p_data_i = $urandom;
            if (p_strobe_o) sn++;
            if (master_r_valid_o) rn++;
            #1;
            if (master_gnt_o) begin
                gn++;
                if (p_strobe_o || master_r_valid_o) ov++;
            end
        end
        @(negedge clk_i);
        master_req_i = 1'b0;
        p_ready_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("b2b_gnts", gn, 10);
        chk("b2b_strobes", sn, 10);
        chk("b2b_rvalids", rn, 10);
        chk("b2b_overlap", ov, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v.addr = BASE - 32'd1 - 32'($urandom_range(0, 1000));
                1:       v.addr = BASE + 32'($urandom_range(0, 32'h3FFF_FFFF));
                2:       v.addr = LIMIT + 32'd1 + 32'($urandom_range(0, 1000));
                default: v.addr = $urandom;
            endcase
            v.we    = 1'($urandom_range(0, 1));
            v.wdata = $urandom;
            v.be    = 4'($urandom);
            v.delay = int'($urandom_range(0, 20));
            v.pdata = $urandom;
            v = model(v);
            run_txn(v, r);
            check_txn($sformatf("rnd%0d", i), v, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
